// File: rtl/ram_pkg.sv
// Shared widths and transaction types for the RAM request sequencer.
package ram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    // One upstream command as held in the command FIFO.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

    // One read result as held in the response buffer.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ram_rsp_t;

endpackage

// File: rtl/ram_sync_fifo.sv
// Synchronous in-order FIFO with registered occupancy count.
// Push is refused when full and pop is ignored when empty, both judged on the
// registered count, so a push never borrows space from a same-cycle pop.
module ram_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Occupancy flags and guarded handshakes.
    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        pop_data = mem[rd_ptr];
    end

    // Storage, pointers and count; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request sequencer for the 16x8 single-port RAM: buffers commands, issues
// one per cycle onto the registered RAM port, captures read data two cycles
// after issue and returns it through an in-order response buffer.
module ram_req_ctrl #(
    parameter int ADDR_W     = ram_pkg::ADDR_W,
    parameter int DATA_W     = ram_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr
);

    import ram_pkg::*;

    localparam int CMD_CW = $clog2(FIFO_DEPTH + 1);
    localparam int RSP_CW = $clog2(RSP_DEPTH + 1);

    ram_cmd_t          cmd_in;
    ram_cmd_t          cmd_head;
    logic [CMD_CW-1:0] cmd_count;
    logic              cmd_push;

    ram_rsp_t          rsp_in;
    ram_rsp_t          rsp_head;
    logic [RSP_CW-1:0] rsp_count;
    logic              rsp_pop;

    logic              issue;
    logic              s1_valid;
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [1:0]        inflight;

    // Upstream handshake, issue decision and response packing.
    always_comb begin
        cmd_in.wr    = cmd_wr;
        cmd_in.addr  = cmd_addr;
        cmd_in.wdata = cmd_wdata;
        cmd_ready    = (cmd_count != CMD_CW'(FIFO_DEPTH));
        cmd_push     = cmd_valid && cmd_ready;

        // Reads still travelling through the RAM have a reserved response slot.
        inflight     = {1'b0, s1_valid} + {1'b0, s2_valid};
        issue        = (cmd_count != '0) &&
                       (cmd_head.wr || ((int'(rsp_count) + int'(inflight)) < RSP_DEPTH));

        rsp_in.addr  = s2_addr;
        rsp_in.data  = dout;
        rsp_valid    = (rsp_count != '0);
        rsp_pop      = rsp_valid && rsp_ready;
        rsp_data     = rsp_head.data;
        rsp_addr     = rsp_head.addr;
    end

    ram_sync_fifo #(
        .T     (ram_cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (issue),
        .pop_data  (cmd_head),
        .count     (cmd_count)
    );

    // RAM port registers: load from the FIFO head on issue, otherwise a benign held read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr   <= 1'b0;
            addr <= '0;
            din  <= '0;
        end else if (issue) begin
            wr   <= cmd_head.wr;
            addr <= cmd_head.addr;
            din  <= cmd_head.wdata;
        end else begin
            wr   <= 1'b0;
        end
    end

    // Read pipeline: stage 1 is the cycle the RAM samples addr, stage 2 the cycle dout is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
        end else begin
            s1_valid <= issue && !cmd_head.wr;
            s2_valid <= s1_valid;
            s2_addr  <= addr;
        end
    end

    ram_sync_fifo #(
        .T     (ram_rsp_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_valid),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .count     (rsp_count)
    );

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl with an attached behavioural 16x8 RAM.
module tb_ram_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [3:0] rsp_addr;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int wr_cnt       = 0;
    int rdy_mode     = 0;   // 0: hold off, 1: always ready, 2: random

    logic [7:0]  ram     [16];
    logic [7:0]  ref_mem [16];
    logic [11:0] exp_q [$];
    logic [11:0] got_q [$];

    always #5 clk = ~clk;

    ram_req_ctrl #(
        .ADDR_W     (4),
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .RSP_DEPTH  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .wr        (wr),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr)
    );

    // Behavioural single-port RAM, write-first, one-cycle read latency.
    always @(posedge clk) begin
        if (wr) ram[addr] <= din;
        dout <= wr ? din : ram[addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Response and write-strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_addr, rsp_data});
            if (wr) wr_cnt = wr_cnt + 1;
        end
    end

    // Consumer back-pressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = (rdy_mode == 1) ? 1'b1 :
                        (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Offer one command; on acceptance the reference model records its effect.
    task automatic send_cmd(input logic w, input logic [3:0] a, input logic [7:0] d,
                            input int max_wait, output bit ok);
        bit r;
        cmd_valid = 1'b1;
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_wdata = d;
        ok        = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        cmd_valid = 1'b0;
        if (ok) begin
            if (w) ref_mem[a] = d;
            else   exp_q.push_back({a, ref_mem[a]});
        end
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int  bad;
        int  n;
        bit  ok;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rdy_mode  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({cmd_ready, wr, addr, din, rsp_valid, rsp_data, rsp_addr} !== {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {cmd_ready, wr, addr, din, rsp_valid, rsp_data, rsp_addr}, 27'h4000000);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Build a burst: a write, then reads that fill the response path.
        n = 0;
        send_cmd(1'b1, 4'h7, 8'($urandom), 10, ok); n += int'(ok);
        for (int i = 1; i <= 3; i++) begin
            send_cmd(1'b0, 4'(i), 8'h00, 10, ok);
            n += int'(ok);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({n[3:0], rsp_valid} !== {4'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL pre_reset_burst: got accepted=%0d rsp_valid=%b expected accepted=4 rsp_valid=1", n, rsp_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cmd_ready, wr, addr, din, rsp_valid, rsp_data, rsp_addr} !== {1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 4'h0}) begin
            tests_failed++;
            $display("FAIL midburst_reset_outputs: got %h expected %h",
                     {cmd_ready, wr, addr, din, rsp_valid, rsp_data, rsp_addr}, 27'h4000000);
        end
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        wr_cnt = 0;
        bad    = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({bad, wr_cnt, got_q.size()} !== {32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: got rsp_valid_cycles=%0d wr_cycles=%0d responses=%0d expected 0 0 0",
                     bad, wr_cnt, got_q.size());
        end
    endtask

    task automatic test_write_read();
        bit ok1;
        bit ok2;
        int acc;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        wr_cnt = 0;
        send_cmd(1'b1, 4'h3, 8'hA5, 10, ok1);
        send_cmd(1'b0, 4'h3, 8'h00, 10, ok2);
        acc = cyc;
        tests_run++;
        if ({ok1, ok2} !== 2'b11) begin
            tests_failed++;
            $display("FAIL wr_rd_accept: got %b expected 11", {ok1, ok2});
        end
        while (cyc < acc + 2) @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_rd_early_valid: got rsp_valid=%b expected 0 at accept+2", rsp_valid);
        end
        @(negedge clk);
        tests_run++;
        if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 4'h3, 8'hA5}) begin
            tests_failed++;
            $display("FAIL wr_rd_latency: got valid=%b addr=%h data=%h expected valid=1 addr=3 data=a5",
                     rsp_valid, rsp_addr, rsp_data);
        end
        @(posedge clk);
        #1;
        wait_rsp(1, 20);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({got_q.size(), wr_cnt} !== {32'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL wr_rd_counts: got responses=%0d wr_cycles=%0d expected 1 1", got_q.size(), wr_cnt);
        end
        tests_run++;
        if (got_q[0] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL wr_rd_model: got %h expected %h", got_q[0], exp_q[0]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_full();
        int n;
        bit ok;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            send_cmd(1'b0, 4'($urandom), 8'h00, 12, ok);
            if (!ok) break;
            n++;
        end
        @(negedge clk);
        tests_run++;
        if ({n, 31'd0, cmd_ready} !== {32'd6, 32'd0}) begin
            tests_failed++;
            $display("FAIL full_accept_count: got accepted=%0d cmd_ready=%b expected 6 0", n, cmd_ready);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_rsp(6, 100);
        repeat (8) @(posedge clk);
        #1;
        tests_run++;
        if (got_q.size() !== 6) begin
            tests_failed++;
            $display("FAIL full_rsp_count: got %0d expected 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL full_rsp_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_ordering();
        bit ok;
        int n;
        int tgt;
        rdy_mode = 2;
        n = 0;
        send_cmd(1'b1, 4'h5, 8'h11, 20, ok); n += int'(ok);
        send_cmd(1'b0, 4'h5, 8'h00, 20, ok); n += int'(ok);
        send_cmd(1'b1, 4'h5, 8'h22, 20, ok); n += int'(ok);
        send_cmd(1'b0, 4'h5, 8'h00, 20, ok); n += int'(ok);
        wait_rsp(2, 200);
        tests_run++;
        if ({n, got_q.size(), got_q[0], got_q[1]} !== {32'd4, 32'd2, 12'h511, 12'h522}) begin
            tests_failed++;
            $display("FAIL order_wrw: got accepted=%0d n=%0d r0=%h r1=%h expected 4 2 511 522",
                     n, got_q.size(), got_q[0], got_q[1]);
        end
        exp_q.delete();
        got_q.delete();
        // Random mixed traffic against the reference memory.
        n = 0;
        for (int i = 0; i < 60; i++) begin
            send_cmd(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 40, ok);
            n += int'(ok);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        tgt = exp_q.size();
        wait_rsp(tgt, 400);
        tests_run++;
        if ({n, got_q.size()} !== {32'd60, tgt}) begin
            tests_failed++;
            $display("FAIL rand_counts: got accepted=%0d responses=%0d expected 60 %0d", n, got_q.size(), tgt);
        end
        for (int i = 0; i < tgt && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_rsp_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_pipeline();
        bit ok;
        int n;
        rdy_mode = 1;
        @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            send_cmd(1'b0, 4'(i), 8'h00, 20, ok);
            n += int'(ok);
        end
        wait_rsp(16, 200);
        tests_run++;
        if ({n, got_q.size()} !== {32'd16, 32'd16}) begin
            tests_failed++;
            $display("FAIL pipe_counts: got accepted=%0d responses=%0d expected 16 16", n, got_q.size());
        end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== {4'(i), ref_mem[i]}) begin
                tests_failed++;
                $display("FAIL pipe_rsp_%0d: got %h expected %h", i, got_q[i], {4'(i), ref_mem[i]});
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_idle();
        bit         ok;
        int         bad;
        logic [7:0] d;
        rdy_mode = 1;
        d = 8'($urandom);
        @(posedge clk);
        #1;
        wr_cnt = 0;
        send_cmd(1'b1, 4'h8, 8'h3C, 10, ok);
        send_cmd(1'b1, 4'h9, d, 10, ok);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (wr_cnt !== 2) begin
            tests_failed++;
            $display("FAIL b2b_write_cycles: got %0d expected 2", wr_cnt);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if ({wr, addr, din} !== {1'b0, 4'h9, d}) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL idle_hold: got %0d bad cycles (last wr=%b addr=%h din=%h) expected 0 (wr=0 addr=9 din=%h)",
                     bad, wr, addr, din, d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_write_read();
        test_full();
        test_ordering();
        test_pipeline();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
